riscv_dmem_ctrl: RTL and testbench
==================================

// Module: riscv_dmem_ctrl
// PURPOSE
//  Parametrised data-memory subsystem for the RISC-V core; successor to the fixed-latency word data memory.
//  Adds a req/ready handshake, configurable wait states, byte/half/word access with sign/zero extension,
//  and optional misaligned-access trapping. Sits between the core LSU and the on-chip data RAM.
// PARAMETERS
//  ADDR_W       32   byte-address width
//  DEPTH        256  number of 32-bit words (power of 2, >=4)
//  WAIT_STATES  1    extra cycles between request acceptance and memory commit (0..15)
// PORTS
//  i_clk        in   1       clock, all logic on rising edge
//  i_rst_n      in   1       reset, synchronous, active-low
//  i_req        in   1       access request, sampled when o_ready=1
//  i_we         in   1       1=store, 0=load
//  i_addr       in   ADDR_W  byte address
//  i_size       in   2       00=byte, 01=half, 10=word, 11=treated as word
//  i_unsigned   in   1       loads: 1=zero-extend, 0=sign-extend
//  i_wdata      in   32      store data, right-justified
//  o_ready      out  1       controller idle, request accepted this cycle if i_req=1
//  o_rvalid     out  1       one-cycle completion pulse (loads and stores)
//  o_rdata      out  32      extended load data, valid with o_rvalid; 0 for stores
//  o_err        out  1       misaligned-access flag, valid with o_rvalid
// BEHAVIOUR
//  Reset (i_rst_n=0 at edge): state=IDLE, counter=0, o_ready=1, o_rvalid=0, o_rdata=0, o_err=0, RAM cleared to 0.
//  FSM: IDLE -> (i_req) WAIT if WAIT_STATES>0 else RESP; WAIT -> RESP when counter hits WAIT_STATES; RESP -> IDLE.
//  Request captured (addr, size, we, unsigned, wdata) at the accepting edge; inputs ignored afterwards.
//  Acceptance in cycle T: RAM read/write commits at edge ending cycle T+WAIT_STATES;
//   o_rvalid=1 only in cycle T+WAIT_STATES+1; o_ready=0 from T+1 through T+WAIT_STATES+1; next accept at T+WAIT_STATES+2.
//  No back-to-back acceptance; i_req while o_ready=0 is ignored (requester holds it).
//  Word index = addr[log2(DEPTH)+1:2]; upper address bits ignored (address wraps modulo 4*DEPTH bytes).
//  Stores: byte-enable from size and addr[1:0]; only enabled lanes written, other lanes preserved.
//  Loads: lane selected by addr[1:0], shifted to bit 0, then sign/zero-extended to 32 bits per i_unsigned.
//  Misaligned: half with addr[0]=1, word with addr[1:0]!=0; handling per CONFIGURATION.
//  Reset mid-operation: pending request dropped, no o_rvalid; a store whose commit edge coincides with reset is not written.
//  o_rdata/o_err hold 0 outside o_rvalid cycles.
// CONFIGURATION
//  DMEM_MISALIGN_TRAP_EN defined: misaligned access not performed (store suppressed, RAM unchanged),
//   completes with normal timing, o_err=1, o_rdata=0.
//  Not defined: low address bits forced aligned (half: addr[0]=0; word: addr[1:0]=0), access performed, o_err tied 0.
// STRUCTURE
//  Package riscv_mem_pkg: size encodings SIZE_B/SIZE_H/SIZE_W, FSM state enum (IDLE/WAIT/RESP), misaligned-check function.
//  Sub-module dmem_lane_align: combinational byte-enable generation, store-lane replication,
//   load-lane extraction and extension; reused by any future cache/LSU.
//  Top: FSM, wait counter, request capture regs, RAM array, response regs.
// TESTING
//  WAIT_STATES=1: store word 0xDEADBEEF @0x10 accepted cycle T -> o_rvalid at T+2, o_ready low T+1..T+2; load @0x10 -> 0xDEADBEEF.
//  Byte store 0x80 @0x13 over 0x00000000 -> word @0x10 reads 0x80000000; lb @0x13 -> 0xFFFFFF80; lbu -> 0x00000080.
//  Half store 0xABCD @0x22, lh @0x22 -> 0xFFFFABCD, lhu -> 0x0000ABCD, word @0x20 -> 0xABCD0000.
//  Misaligned sw 0x12345678 @0x31: with macro -> o_err=1, word @0x30 unchanged; without -> written to 0x30, o_err=0.
//  DEPTH=256: store @0x400 aliases @0x000; WAIT_STATES=0 gives o_rvalid at T+1; i_req held during busy accepted only when o_ready=1.
//  Reset asserted during WAIT of a store -> no o_rvalid, target word reads 0 after reset; o_ready=1 cycle after reset.

Source files
------------

// File: rtl/riscv_mem_pkg.sv
// Shared types and helpers for the data-memory subsystem.
// Size encodings, controller state enum and alignment helpers.
package riscv_mem_pkg;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  function automatic logic misaligned(
    input logic [1:0] size,
    input logic [1:0] lo
  );
    logic m;
    if (size == SIZE_B)
      m = 1'b0;
    else if (size == SIZE_H)
      m = lo[0];
    else
      m = |lo;
    return m;
  endfunction

  // Size 2'b11 behaves as a word access.
  function automatic logic [1:0] align_lo(
    input logic [1:0] size,
    input logic [1:0] lo
  );
    logic [1:0] a;
    if (size == SIZE_B)
      a = lo;
    else if (size == SIZE_H)
      a = {lo[1], 1'b0};
    else
      a = 2'b00;
    return a;
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering for sub-word loads and stores.
// Byte enables, store replication, load extraction and extension.
module dmem_lane_align
  import riscv_mem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  lo,
  input  logic        uns,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  be,
  output logic [31:0] wword,
  output logic [31:0] rdata
);

  logic [31:0] shifted;
  logic        is_b;
  logic        is_h;

  assign is_b    = size == SIZE_B;
  assign is_h    = size == SIZE_H;
  assign shifted = rword >> {lo, 3'b000};

  always_comb begin
    be    = 4'b1111;
    wword = wdata;
    rdata = rword;
    unique case (1'b1)
      is_b: begin
        be    = 4'b0001 << lo;
        wword = {4{wdata[7:0]}};
        rdata = {{24{~uns & shifted[7]}}, shifted[7:0]};
      end
      is_h: begin
        be    = lo[1] ? 4'b1100 : 4'b0011;
        wword = {2{wdata[15:0]}};
        rdata = {{16{~uns & shifted[15]}}, shifted[15:0]};
      end
      default: begin
        be    = 4'b1111;
        wword = wdata;
        rdata = rword;
      end
    endcase
  end

endmodule

// File: rtl/riscv_dmem_ctrl.sv
// Data-memory controller: req/ready handshake, wait states, sub-word access.
// Define DMEM_MISALIGN_TRAP_EN to trap misaligned accesses via o_err.
module riscv_dmem_ctrl
  import riscv_mem_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_req,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [1:0]        i_size,
  input  logic              i_unsigned,
  input  logic [31:0]       i_wdata,
  output logic              o_ready,
  output logic              o_rvalid,
  output logic [31:0]       o_rdata,
  output logic              o_err
);

  localparam int         IDX_W = $clog2(DEPTH);
  localparam int         LOC_W = IDX_W + 2;
  localparam logic [3:0] WS    = 4'(WAIT_STATES);

  state_t            state;
  logic [3:0]        cnt;
  logic [LOC_W-1:0]  cap_addr;
  logic [1:0]        cap_size;
  logic              cap_we;
  logic              cap_uns;
  logic [31:0]       cap_wdata;
  logic [31:0]       mem [DEPTH];

  logic              ready;
  logic              rvalid;
  logic [31:0]       rdata;
  logic              err;

  logic              idle;
  logic [LOC_W-1:0]  a_addr;
  logic [1:0]        a_size;
  logic              a_we;
  logic              a_uns;
  logic [31:0]       a_wdata;
  logic [1:0]        lo;
  logic [IDX_W-1:0]  idx;
  logic              mis;
  logic              block;
  logic              commit;
  logic [3:0]        be;
  logic [31:0]       wword;
  logic [31:0]       ext;
  logic              unused_bits;

  // With zero wait states the commit happens on the accepting edge,
  // so the live request is used while idle.
  assign idle    = state == IDLE;
  assign a_addr  = idle ? i_addr[LOC_W-1:0] : cap_addr;
  assign a_size  = idle ? i_size : cap_size;
  assign a_we    = idle ? i_we : cap_we;
  assign a_uns   = idle ? i_unsigned : cap_uns;
  assign a_wdata = idle ? i_wdata : cap_wdata;
  assign idx     = a_addr[LOC_W-1:2];
  assign mis     = misaligned(a_size, a_addr[1:0]);

`ifdef DMEM_MISALIGN_TRAP_EN
  assign lo    = a_addr[1:0];
  assign block = mis;
`else
  assign lo    = align_lo(a_size, a_addr[1:0]);
  assign block = 1'b0;
`endif

  assign commit = (idle && i_req && WAIT_STATES == 0)
               || (state == WAIT && cnt == WS);

  assign unused_bits = ^{i_addr[ADDR_W-1:LOC_W], mis};

  dmem_lane_align u_align (
    .size  (a_size),
    .lo    (lo),
    .uns   (a_uns),
    .wdata (a_wdata),
    .rword (mem[idx]),
    .be    (be),
    .wword (wword),
    .rdata (ext)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      ready     <= 1'b1;
      rvalid    <= 1'b0;
      rdata     <= '0;
      err       <= 1'b0;
      cap_addr  <= '0;
      cap_size  <= SIZE_W;
      cap_we    <= 1'b0;
      cap_uns   <= 1'b0;
      cap_wdata <= '0;
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
    end else begin
      rvalid <= 1'b0;
      rdata  <= '0;
      err    <= 1'b0;
      if (commit) begin
        rvalid <= 1'b1;
        err    <= block;
        if (!a_we && !block)
          rdata <= ext;
        if (a_we && !block)
          for (int b = 0; b < 4; b++)
            if (be[b])
              mem[idx][8*b +: 8] <= wword[8*b +: 8];
      end
      unique case (state)
        IDLE: begin
          if (i_req) begin
            cap_addr  <= i_addr[LOC_W-1:0];
            cap_size  <= i_size;
            cap_we    <= i_we;
            cap_uns   <= i_unsigned;
            cap_wdata <= i_wdata;
            ready     <= 1'b0;
            if (WAIT_STATES == 0) begin
              state <= RESP;
            end else begin
              state <= WAIT;
              cnt   <= 4'd1;
            end
          end
        end
        WAIT: begin
          if (cnt == WS) begin
            state <= RESP;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        RESP: begin
          state <= IDLE;
          ready <= 1'b1;
        end
        default: begin
          state <= IDLE;
          ready <= 1'b1;
        end
      endcase
    end
  end

  assign o_ready  = ready;
  assign o_rvalid = rvalid;
  assign o_rdata  = rdata;
  assign o_err    = err;

endmodule

// File: tb/tb_riscv_dmem_ctrl.sv
// Directed bench for riscv_dmem_ctrl (WAIT_STATES=1 and =0 instances).
// Expectations follow DMEM_MISALIGN_TRAP_EN when it is defined.
module tb_riscv_dmem_ctrl;

  localparam logic [1:0] SB = 2'b00;
  localparam logic [1:0] SH = 2'b01;
  localparam logic [1:0] SW = 2'b10;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0 = 1'b0;
  logic        req1 = 1'b0;
  logic        we = 1'b0;
  logic [31:0] addr = '0;
  logic [1:0]  size = SW;
  logic        uns = 1'b0;
  logic [31:0] wdata = '0;
  logic        rdy0, rv0, er0;
  logic        rdy1, rv1, er1;
  logic [31:0] rd0, rd1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  riscv_dmem_ctrl #(.ADDR_W(32), .DEPTH(256), .WAIT_STATES(1)) dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req0), .i_we(we),
    .i_addr(addr), .i_size(size), .i_unsigned(uns), .i_wdata(wdata),
    .o_ready(rdy0), .o_rvalid(rv0), .o_rdata(rd0), .o_err(er0)
  );

  riscv_dmem_ctrl #(.ADDR_W(32), .DEPTH(256), .WAIT_STATES(0)) dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req1), .i_we(we),
    .i_addr(addr), .i_size(size), .i_unsigned(uns), .i_wdata(wdata),
    .o_ready(rdy1), .o_rvalid(rv1), .o_rdata(rd1), .o_err(er1)
  );

  function automatic logic rdy(input bit sel);
    return sel ? rdy1 : rdy0;
  endfunction

  // One access; inputs are scrambled after acceptance to prove capture.
  task automatic acc(
    input  bit          sel,
    input  logic        w,
    input  logic [31:0] a,
    input  logic [1:0]  sz,
    input  logic        u,
    input  logic [31:0] d,
    output logic [31:0] rd,
    output logic        er,
    output int          lat,
    output logic        busy_ok,
    output logic        rdy_after
  );
    int n;
    n = 0;
    rd = '0; er = 1'b0; lat = -1; busy_ok = 1'b1; rdy_after = 1'b0;
    while (!rdy(sel) && n < 50) begin
      @(posedge clk); #1; n++;
    end
    we = w; addr = a; size = sz; uns = u; wdata = d;
    if (sel) req1 = 1'b1; else req0 = 1'b1;
    @(posedge clk); #1;
    req0 = 1'b0; req1 = 1'b0;
    we = ~w; addr = ~a; size = ~sz; uns = ~u; wdata = ~d;
    for (int k = 1; k <= 40; k++) begin
      if (rdy(sel)) busy_ok = 1'b0;
      if (sel ? rv1 : rv0) begin
        lat = k;
        rd = sel ? rd1 : rd0;
        er = sel ? er1 : er0;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    rdy_after = rdy(sel);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (rdy0 !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b want 1", rdy0); end
    checks++; if (rv0 !== 1'b0) begin errors++; $display("FAIL rst_rvalid: got %b want 0", rv0); end
    checks++; if (rd0 !== 32'h0) begin errors++; $display("FAIL rst_rdata: got %h want 0", rd0); end
    checks++; if (er0 !== 1'b0) begin errors++; $display("FAIL rst_err: got %b want 0", er0); end
    checks++; if (rdy1 !== 1'b1) begin errors++; $display("FAIL rst_ready_ws0: got %b want 1", rdy1); end
    rst_n = 1'b1;
  endtask

  task automatic test_word;
    logic [31:0] rd; logic er, bo, ra; int lat;
    acc(0, 1, 32'h10, SW, 0, 32'hDEADBEEF, rd, er, lat, bo, ra);
    checks++; if (lat !== 2) begin errors++; $display("FAIL sw_latency: got %0d want 2", lat); end
    checks++; if (bo !== 1'b1) begin errors++; $display("FAIL sw_busy: ready seen high while busy"); end
    checks++; if (ra !== 1'b1) begin errors++; $display("FAIL sw_ready_after: got %b want 1", ra); end
    checks++; if (rd !== 32'h0 || er !== 1'b0) begin errors++; $display("FAIL sw_resp: got %h/%b want 0/0", rd, er); end
    acc(0, 0, 32'h10, SW, 0, 32'h0, rd, er, lat, bo, ra);
    checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_data: got %h want deadbeef", rd); end
    checks++; if (lat !== 2) begin errors++; $display("FAIL lw_latency: got %0d want 2", lat); end
  endtask

  task automatic test_byte;
    logic [31:0] rd; logic er, bo, ra; int lat;
    acc(0, 1, 32'h10, SW, 0, 32'h0, rd, er, lat, bo, ra);
    acc(0, 1, 32'h13, SB, 0, 32'h1234_5680, rd, er, lat, bo, ra);
    acc(0, 0, 32'h10, SW, 0, 32'h0, rd, er, lat, bo, ra);
    checks++; if (rd !== 32'h80000000) begin errors++; $display("FAIL sb_word: got %h want 80000000", rd); end
    acc(0, 0, 32'h13, SB, 0, 32'h0, rd, er, lat, bo, ra);
    checks++; if (rd !== 32'hFFFFFF80) begin errors++; $display("FAIL lb: got %h want ffffff80", rd); end
    acc(0, 0, 32'h13, SB, 1, 32'h0, rd, er, lat, bo, ra);
    checks++; if (rd !== 32'h00000080) begin errors++; $display("FAIL lbu: got %h want 00000080", rd); end
  endtask

  task automatic test_half;
    logic [31:0] rd; logic er, bo, ra; int lat;
    acc(0, 1, 32'h22, SH, 0, 32'h5555_ABCD, rd, er, lat, bo, ra);
    acc(0, 0, 32'h22, SH, 0, 32'h0, rd, er, lat, bo, ra);
    checks++; if (rd !== 32'hFFFFABCD) begin errors++; $display("FAIL lh: got %h want ffffabcd", rd); end
    acc(0, 0, 32'h22, SH, 1, 32'h0, rd, er, lat, bo, ra);
    checks++; if (rd !== 32'h0000ABCD) begin errors++; $display("FAIL lhu: got %h want 0000abcd", rd); end
    acc(0, 0, 32'h20, SW, 0, 32'h0, rd, er, lat, bo, ra);
    checks++; if (rd !== 32'hABCD0000) begin errors++; $display("FAIL sh_word: got %h want abcd0000", rd); end
  endtask

  task automatic test_misalign;
    logic [31:0] rd, x_word, x_half; logic er, bo, ra, x_err; int lat;
`ifdef DMEM_MISALIGN_TRAP_EN
    x_err = 1'b1; x_word = 32'h11111111; x_half = 32'h0;
`else
    x_err = 1'b0; x_word = 32'h12345678; x_half = 32'h00001234;
`endif
    acc(0, 1, 32'h30, SW, 0, 32'h11111111, rd, er, lat, bo, ra);
    acc(0, 1, 32'h31, SW, 0, 32'h12345678, rd, er, lat, bo, ra);
    checks++; if (er !== x_err) begin errors++; $display("FAIL mis_sw_err: got %b want %b", er, x_err); end
    checks++; if (lat !== 2) begin errors++; $display("FAIL mis_sw_latency: got %0d want 2", lat); end
    acc(0, 0, 32'h30, SW, 0, 32'h0, rd, er, lat, bo, ra);
    checks++; if (rd !== x_word) begin errors++; $display("FAIL mis_word: got %h want %h", rd, x_word); end
    acc(0, 0, 32'h33, SH, 0, 32'h0, rd, er, lat, bo, ra);
    checks++; if (rd !== x_half || er !== x_err) begin errors++; $display("FAIL mis_lh: got %h/%b want %h/%b", rd, er, x_half, x_err); end
  endtask

  task automatic test_alias;
    logic [31:0] rd; logic er, bo, ra; int lat;
    acc(0, 1, 32'h400, SW, 0, 32'hCAFEF00D, rd, er, lat, bo, ra);
    acc(0, 0, 32'h0, SW, 0, 32'h0, rd, er, lat, bo, ra);
    checks++; if (rd !== 32'hCAFEF00D) begin errors++; $display("FAIL alias_400: got %h want cafef00d", rd); end
    acc(0, 0, 32'h8000_0000, SW, 0, 32'h0, rd, er, lat, bo, ra);
    checks++; if (rd !== 32'hCAFEF00D) begin errors++; $display("FAIL alias_high: got %h want cafef00d", rd); end
  endtask

  task automatic test_ws0;
    logic [31:0] rd; logic er, bo, ra; int lat;
    acc(1, 1, 32'h8, SW, 0, 32'h0BAD_F00D, rd, er, lat, bo, ra);
    checks++; if (lat !== 1) begin errors++; $display("FAIL ws0_sw_latency: got %0d want 1", lat); end
    checks++; if (bo !== 1'b1 || ra !== 1'b1) begin errors++; $display("FAIL ws0_ready: got busy_ok=%b after=%b want 1/1", bo, ra); end
    acc(1, 0, 32'h8, SW, 0, 32'h0, rd, er, lat, bo, ra);
    checks++; if (rd !== 32'h0BADF00D || lat !== 1) begin errors++; $display("FAIL ws0_lw: got %h lat %0d want 0badf00d lat 1", rd, lat); end
  endtask

  task automatic test_back_to_back;
    int rv_cyc[2]; int nrv; int busy_bad; logic [31:0] second_rd;
    nrv = 0; busy_bad = 0; second_rd = '0; rv_cyc[0] = -1; rv_cyc[1] = -1;
    we = 1'b1; addr = 32'h40; size = SW; uns = 1'b0; wdata = 32'hA5A50F0F;
    req0 = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      if (k == 1) we = 1'b0;
      if (rv0) begin
        if (nrv < 2) rv_cyc[nrv] = k;
        if (nrv == 1) second_rd = rd0;
        nrv++;
      end
      if ((k == 1 || k == 2 || k == 4 || k == 5) && rdy0) busy_bad++;
      if (k == 4) req0 = 1'b0;
    end
    checks++; if (nrv !== 2) begin errors++; $display("FAIL b2b_count: got %0d want 2", nrv); end
    checks++; if (rv_cyc[0] !== 2 || rv_cyc[1] !== 5) begin errors++; $display("FAIL b2b_timing: got %0d,%0d want 2,5", rv_cyc[0], rv_cyc[1]); end
    checks++; if (second_rd !== 32'hA5A50F0F) begin errors++; $display("FAIL b2b_data: got %h want a5a50f0f", second_rd); end
    checks++; if (busy_bad !== 0) begin errors++; $display("FAIL b2b_busy: got %0d want 0", busy_bad); end
  endtask

  task automatic test_reset_mid;
    logic [31:0] rd; logic er, bo, ra; int lat; int stray;
    stray = 0;
    we = 1'b1; addr = 32'h50; size = SW; uns = 1'b0; wdata = 32'h5555AAAA;
    req0 = 1'b1;
    @(posedge clk); #1;
    req0 = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    checks++; if (rv0 !== 1'b0 || rdy0 !== 1'b1) begin errors++; $display("FAIL rstmid_state: got rvalid=%b ready=%b want 0/1", rv0, rdy0); end
    for (int k = 0; k < 4; k++) begin
      if (rv0) stray++;
      @(posedge clk); #1;
    end
    checks++; if (stray !== 0) begin errors++; $display("FAIL rstmid_rvalid: got %0d pulses want 0", stray); end
    acc(0, 0, 32'h50, SW, 0, 32'h0, rd, er, lat, bo, ra);
    checks++; if (rd !== 32'h0 || lat !== 2) begin errors++; $display("FAIL rstmid_word: got %h lat %0d want 0 lat 2", rd, lat); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_word();
    test_byte();
    test_half();
    test_misalign();
    test_alias();
    test_ws0();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
